// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Sequencer for an 8-bit add/shl ALU. It owns a 4-entry register
//               file, issues one instruction at a time and writes the result
//               back. Optional overflow flag output under ALU_SEQ_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int NREGS   = 4,
    parameter int DW      = 8,
    parameter int ALU_LAT = 1
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_instr,
    input  logic          ld_valid,
    input  logic [1:0]    ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic [1:0]    rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_imm,
    output logic          alu_op,
    input  logic [DW-1:0] alu_result,
    output logic          done,
    output logic [DW-1:0] res
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic          ovf
`endif
);

    localparam int CW = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_rd;
    logic [DW-1:0] r_regs [NREGS];

    wire [1:0] w_rd  = in_instr[6:5];
    wire [1:0] w_rs1 = in_instr[4:3];
    wire [1:0] w_rs2 = in_instr[1:0];

    assign in_ready = (r_state == S_IDLE) && !ld_valid;
    assign rd_data  = r_regs[rd_addr];

`ifdef ALU_SEQ_OVF_EN
    localparam int SW = $clog2(DW) + 1;

    // Flag is derived from the issued operands, which are held stable until WB.
    logic [DW-1:0] w_sum;
    logic [SW-1:0] w_rsh;
    logic          w_ovf;
    always_comb begin
        w_sum = alu_a + alu_b;
        w_rsh = SW'(DW) - SW'(alu_imm);
        if (alu_op)
            w_ovf = (w_sum < alu_a);
        else if (alu_imm == 3'd0)
            w_ovf = 1'b0;
        else
            w_ovf = |(alu_a >> w_rsh);
    end
`endif

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rd    <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_imm <= '0;
            alu_op  <= 1'b0;
            done    <= 1'b0;
            res     <= '0;
`ifdef ALU_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ld_valid) begin
                        r_regs[ld_addr] <= ld_data;
                    end else if (in_valid) begin
                        alu_a   <= r_regs[w_rs1];
                        alu_b   <= in_instr[7] ? r_regs[w_rs2] : '0;
                        alu_imm <= in_instr[2:0];
                        alu_op  <= in_instr[7];
                        r_rd    <= w_rd;
                        r_cnt   <= CW'(ALU_LAT);
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) r_state <= S_WB;
                end
                S_WB: begin
                    r_regs[r_rd] <= alu_result;
                    res          <= alu_result;
                    done         <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
                    ovf          <= w_ovf;
`endif
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Self-checking bench for alu_seq_ctrl with a registered ALU
//               model and a behavioural register-file reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int DW      = 8;
    localparam int ALU_LAT = 1;

    logic          sysclk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_instr = 8'h00;
    logic          ld_valid = 1'b0;
    logic [1:0]    ld_addr = 2'd0;
    logic [DW-1:0] ld_data = '0;
    logic [1:0]    rd_addr = 2'd0;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic [2:0]    alu_imm;
    logic          alu_op;
    logic          done;
    logic [DW-1:0] res;
`ifdef ALU_SEQ_OVF_EN
    logic          ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] m_regs [4];

    always #5 sysclk = ~sysclk;

    // Registered ALU: one edge from operands to result.
    always @(posedge sysclk)
        alu_result <= alu_op ? (alu_a + alu_b) : (alu_a << alu_imm);

    alu_seq_ctrl #(.NREGS(4), .DW(DW), .ALU_LAT(ALU_LAT)) dut (
        .sysclk(sysclk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_op(alu_op),
        .alu_result(alu_result),
`ifdef ALU_SEQ_OVF_EN
        .ovf(ovf),
`endif
        .done(done), .res(res)
    );

    // Reference: full-precision result, truncated to DW; overflow if it did not fit.
    function automatic int model_full(input logic [7:0] ins);
        int a, b;
        a = int'(m_regs[ins[4:3]]);
        b = int'(m_regs[ins[1:0]]);
        return ins[7] ? (a + b) : (a << ins[2:0]);
    endfunction

    task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
        @(negedge sysclk);
        ld_valid = 1'b1; ld_addr = addr; ld_data = data;
        @(negedge sysclk);
        ld_valid = 1'b0;
        m_regs[addr] = data;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [7:0] val);
        rd_addr = addr;
        #1 val = rd_data;
    endtask

    // Issues one instruction and reports what was observed; no judgement here.
    task automatic exec(input logic [7:0] ins, output int lat, output logic [7:0] r,
                        output logic o, output logic [7:0] a, output logic [7:0] b,
                        output logic [2:0] im, output logic op, output bit to,
                        output logic pulse2);
        int n;
        to = 1'b0; o = 1'b0;
        @(negedge sysclk);
        in_valid = 1'b1; in_instr = ins;
        n = 0;
        while (!in_ready && n < 10) begin @(negedge sysclk); n++; end
        if (!in_ready) to = 1'b1;
        @(posedge sysclk);
        #1 in_valid = 1'b0;
        @(negedge sysclk);
        a = alu_a; b = alu_b; im = alu_imm; op = alu_op;
        lat = 0;
        while (!done && lat < 12) begin @(negedge sysclk); lat++; end
        if (!done) to = 1'b1;
        r = res;
`ifdef ALU_SEQ_OVF_EN
        o = ovf;
`endif
        @(negedge sysclk);
        pulse2 = done;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        rst = 1'b1;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (res !== 8'h00) begin bad++; $display("FAIL reset_res got=%h exp=00", res); end
        total++;
        if ({alu_a, alu_b, alu_imm, alu_op} !== 20'h0) begin
            bad++; $display("FAIL reset_alu got=%h/%h/%h/%b exp=0", alu_a, alu_b, alu_imm, alu_op);
        end
`ifdef ALU_SEQ_OVF_EN
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            total++; if (v !== 8'h00) begin bad++; $display("FAIL reset_reg%0d got=%h exp=00", i, v); end
        end
    endtask

    task automatic test_directed;
        logic [7:0] r1v [3] = '{8'h05, 8'h81, 8'hFF};
        logic [7:0] r2v [3] = '{8'h03, 8'h3C, 8'h01};
        logic [7:0] ins [3] = '{8'h8A, 8'h69, 8'hCA};
        logic [7:0] er  [3] = '{8'h08, 8'h02, 8'h00};
        logic [7:0] eb  [3] = '{8'h03, 8'h00, 8'h01};
        logic [1:0] erd [3] = '{2'd0, 2'd3, 2'd2};
        logic       eo  [3] = '{1'b0, 1'b1, 1'b1};
        int lat; logic [7:0] r, a, b, v; logic o, op, p2; logic [2:0] im; bit to;
        for (int c = 0; c < 3; c++) begin
            do_load(2'd1, r1v[c]);
            do_load(2'd2, r2v[c]);
            exec(ins[c], lat, r, o, a, b, im, op, to, p2);
            m_regs[erd[c]] = er[c];
            total++; if (to) begin bad++; $display("FAIL dir%0d_timeout got=1 exp=0", c); end
            total++; if (lat !== ALU_LAT + 1) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", c, lat, ALU_LAT + 1); end
            total++; if (r !== er[c]) begin bad++; $display("FAIL dir%0d_res got=%h exp=%h", c, r, er[c]); end
            total++; if (a !== r1v[c] || b !== eb[c]) begin bad++; $display("FAIL dir%0d_operands got=%h/%h exp=%h/%h", c, a, b, r1v[c], eb[c]); end
            total++; if (op !== ins[c][7] || im !== ins[c][2:0]) begin bad++; $display("FAIL dir%0d_opimm got=%b/%h exp=%b/%h", c, op, im, ins[c][7], ins[c][2:0]); end
            total++; if (p2 !== 1'b0) begin bad++; $display("FAIL dir%0d_pulse_width got=%b exp=0", c, p2); end
            read_reg(erd[c], v);
            total++; if (v !== er[c]) begin bad++; $display("FAIL dir%0d_wb got=%h exp=%h", c, v, er[c]); end
`ifdef ALU_SEQ_OVF_EN
            total++; if (o !== eo[c]) begin bad++; $display("FAIL dir%0d_ovf got=%b exp=%b", c, o, eo[c]); end
`else
            if (o !== 1'b0 && eo[c] === 1'b0) $display("note: unexpected ovf value");
`endif
        end
    endtask

    task automatic test_load_priority;
        logic [7:0] ins, v; int full, n;
        ins = 8'hD0 | 8'h02;               // add rd=2 rs1=2 rs2=2
        @(negedge sysclk);
        ld_valid = 1'b1; ld_addr = 2'd2; ld_data = 8'h44;
        in_valid = 1'b1; in_instr = ins;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ldpri_ready got=%b exp=0", in_ready); end
        @(negedge sysclk);
        ld_valid = 1'b0;
        m_regs[2] = 8'h44;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ldpri_ready_next got=%b exp=1", in_ready); end
        read_reg(2'd2, v);
        total++; if (v !== 8'h44) begin bad++; $display("FAIL ldpri_load got=%h exp=44", v); end
        @(posedge sysclk);
        #1 in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ldpri_busy got=%b exp=0", in_ready); end
        full = model_full(ins);
        m_regs[2] = 8'(full);
        n = 0;
        @(negedge sysclk);
        while (!done && n < 10) begin @(negedge sysclk); n++; end
        total++; if (res !== 8'h88 || done !== 1'b1) begin bad++; $display("FAIL ldpri_res got=%h done=%b exp=88", res, done); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] insa, insb, ea, eb, v;
        logic er [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        insa = 8'hB3;                      // add rd=1 rs1=2 rs2=3
        insb = 8'h6B;                      // shl rd=3 rs1=1 imm=3
        do_load(2'd2, 8'h70);
        do_load(2'd3, 8'h15);
        do_load(2'd0, 8'h11);
        ea = 8'(model_full(insa)); m_regs[1] = ea;
        eb = 8'(model_full(insb)); m_regs[3] = eb;
        @(negedge sysclk);
        in_valid = 1'b1; in_instr = insa;
        @(posedge sysclk);
        #1 in_instr = insb;
        for (int k = 0; k < 6; k++) begin
            @(negedge sysclk);
            ld_valid = (k == 0);           // load while busy must be dropped
            ld_addr = 2'd0; ld_data = 8'h5A;
            #1;
            total++; if (in_ready !== er[k]) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=%b", k, in_ready, er[k]); end
            total++; if (done !== er[k]) begin bad++; $display("FAIL b2b_done%0d got=%b exp=%b", k, done, er[k]); end
            if (k == 2) begin
                total++; if (res !== ea) begin bad++; $display("FAIL b2b_resA got=%h exp=%h", res, ea); end
                @(posedge sysclk);
                #1 in_valid = 1'b0;
            end
            if (k == 5) begin
                total++; if (res !== eb) begin bad++; $display("FAIL b2b_resB got=%h exp=%h", res, eb); end
            end
        end
        ld_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_reg(2'(i), v);
            total++; if (v !== m_regs[i]) begin bad++; $display("FAIL b2b_reg%0d got=%h exp=%h", i, v, m_regs[i]); end
        end
    endtask

    task automatic test_random;
        int lat, full; logic [7:0] ins, r, a, b, v, ea, eb; logic o, op, p2; logic [2:0] im; bit to;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) do_load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            ins = 8'($urandom_range(0, 255));
            ea = m_regs[ins[4:3]];
            eb = ins[7] ? m_regs[ins[1:0]] : 8'h00;
            full = model_full(ins);
            exec(ins, lat, r, o, a, b, im, op, to, p2);
            m_regs[ins[6:5]] = 8'(full);
            total++;
            if (to || lat !== ALU_LAT + 1 || p2 !== 1'b0) begin
                bad++; $display("FAIL rnd%0d_timing got=lat%0d/to%0d/p%b exp=lat%0d", it, lat, to, p2, ALU_LAT + 1);
            end
            total++; if (r !== 8'(full)) begin bad++; $display("FAIL rnd%0d_res ins=%h got=%h exp=%h", it, ins, r, 8'(full)); end
            total++;
            if (a !== ea || b !== eb || im !== ins[2:0] || op !== ins[7]) begin
                bad++; $display("FAIL rnd%0d_issue got=%h/%h/%h/%b exp=%h/%h/%h/%b", it, a, b, im, op, ea, eb, ins[2:0], ins[7]);
            end
`ifdef ALU_SEQ_OVF_EN
            total++; if (o !== (full > 255)) begin bad++; $display("FAIL rnd%0d_ovf ins=%h got=%b exp=%b", it, ins, o, full > 255); end
`endif
            for (int i = 0; i < 4; i++) begin
                read_reg(2'(i), v);
                total++; if (v !== m_regs[i]) begin bad++; $display("FAIL rnd%0d_reg%0d got=%h exp=%h", it, i, v, m_regs[i]); end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] v; int seen;
        for (int d = 1; d <= 2; d++) begin
            do_load(2'd1, 8'h21);
            do_load(2'd2, 8'h34);
            @(negedge sysclk);
            in_valid = 1'b1; in_instr = 8'h8A;
            @(posedge sysclk);
            #1 in_valid = 1'b0;
            repeat (d) @(negedge sysclk);
            rst = 1'b1;                    // lands in WAIT (d=1) or WB (d=2)
            @(negedge sysclk);
            rst = 1'b0;
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid%0d_ready got=%b exp=1", d, in_ready); end
            total++; if (res !== 8'h00 || alu_a !== 8'h00 || alu_b !== 8'h00) begin bad++; $display("FAIL rstmid%0d_clear got=%h/%h/%h exp=0", d, res, alu_a, alu_b); end
            seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (done) seen++;
                @(negedge sysclk);
            end
            total++; if (seen != 0) begin bad++; $display("FAIL rstmid%0d_done got=%0d exp=0", d, seen); end
            for (int i = 0; i < 4; i++) begin
                read_reg(2'(i), v);
                total++; if (v !== 8'h00) begin bad++; $display("FAIL rstmid%0d_reg%0d got=%h exp=00", d, i, v); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_load_priority;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
